// File: rtl/matrix_3x3_gen_8bit_if.sv
// Pixel-window bus for the 3x3 generator: upstream video, line-RAM taps,
// and the registered window with its delayed syncs.
interface matrix_3x3_gen_8bit_if;
  logic       pre_frame_vsync;
  logic       pre_frame_href;
  logic       pre_frame_clken;
  logic [7:0] pre_img_y;
  logic [7:0] row1_tap;
  logic [7:0] row2_tap;

  logic       post_frame_vsync;
  logic       post_frame_href;
  logic       post_frame_clken;
  logic       post_win_valid;
  logic [7:0] m11, m12, m13;
  logic [7:0] m21, m22, m23;
  logic [7:0] m31, m32, m33;

  modport master (
    output pre_frame_vsync, pre_frame_href, pre_frame_clken, pre_img_y,
    output row1_tap, row2_tap,
    input  post_frame_vsync, post_frame_href, post_frame_clken, post_win_valid,
    input  m11, m12, m13, m21, m22, m23, m31, m32, m33
  );

  modport slave (
    input  pre_frame_vsync, pre_frame_href, pre_frame_clken, pre_img_y,
    input  row1_tap, row2_tap,
    output post_frame_vsync, post_frame_href, post_frame_clken, post_win_valid,
    output m11, m12, m13, m21, m22, m23, m31, m32, m33
  );
endinterface

// File: rtl/matrix_3x3_gen_8bit.sv
// 3x3 sliding pixel window built from the current line and two line-RAM taps,
// with 2-cycle delayed syncs and a flag marking windows fully inside the image.
module matrix_3x3_gen_8bit #(
  parameter int IMG_HOR = 640,
  parameter int IMG_VER = 480,
  parameter int CNT_W   = 10
) (
  input logic                  clk,
  input logic                  rst_n,
  matrix_3x3_gen_8bit_if.slave bus
);
  localparam logic [CNT_W-1:0] COL_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ROW_MAX = CNT_W'(IMG_VER - 1);
  localparam logic [CNT_W-1:0] MIN_IDX = CNT_W'(2);
  // An image that does not fit the counters leaves the block permanently disarmed.
  localparam logic CFG_OK = (IMG_HOR <= (1 << CNT_W)) && (IMG_VER <= (1 << CNT_W));

  logic [7:0]       row3_d_reg;
  logic             vsync_d1_reg, href_d1_reg, clken_d1_reg;
  logic             vsync_d2_reg, href_d2_reg, clken_d2_reg;
  logic             win_valid_reg, win_valid_next;
  logic             armed_reg, armed_next;
  logic [CNT_W-1:0] col_cnt_reg, col_cnt_next;
  logic [CNT_W-1:0] row_cnt_reg, row_cnt_next;
  logic             vsync_rise, href_fall;
  logic [7:0]       col_in [3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row3_d_reg   <= 8'd0;
      vsync_d1_reg <= 1'b0;
      href_d1_reg  <= 1'b0;
      clken_d1_reg <= 1'b0;
    end else begin
      row3_d_reg   <= bus.pre_img_y;
      vsync_d1_reg <= bus.pre_frame_vsync;
      href_d1_reg  <= bus.pre_frame_href;
      clken_d1_reg <= bus.pre_frame_clken;
    end
  end

  // The RAM taps arrive one cycle after the pixel, so they line up with row3_d_reg.
  assign col_in[0] = bus.row1_tap;
  assign col_in[1] = bus.row2_tap;
  assign col_in[2] = row3_d_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_row
      logic [7:0] px_reg [3];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          px_reg[0] <= 8'd0;
          px_reg[1] <= 8'd0;
          px_reg[2] <= 8'd0;
        end else if (clken_d1_reg) begin
          px_reg[0] <= px_reg[1];
          px_reg[1] <= px_reg[2];
          px_reg[2] <= col_in[gi];
        end
      end
    end
  endgenerate

  assign vsync_rise = vsync_d1_reg & ~vsync_d2_reg;
  assign href_fall  = ~href_d1_reg & href_d2_reg;

  always_comb begin
    col_cnt_next = col_cnt_reg;
    if (!href_d1_reg) begin
      col_cnt_next = '0;
    end else if (clken_d1_reg && (col_cnt_reg != COL_MAX)) begin
      col_cnt_next = col_cnt_reg + 1'b1;
    end

    // A frame start in the same cycle as a line end wins: the row restarts at 0.
    row_cnt_next = row_cnt_reg;
    if (vsync_rise) begin
      row_cnt_next = '0;
    end else if (href_fall && (row_cnt_reg != ROW_MAX)) begin
      row_cnt_next = row_cnt_reg + 1'b1;
    end

    armed_next     = armed_reg | (vsync_rise & CFG_OK);
    win_valid_next = armed_reg & clken_d1_reg &
                     (col_cnt_reg >= MIN_IDX) & (row_cnt_reg >= MIN_IDX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d2_reg  <= 1'b0;
      href_d2_reg   <= 1'b0;
      clken_d2_reg  <= 1'b0;
      win_valid_reg <= 1'b0;
      armed_reg     <= 1'b0;
      col_cnt_reg   <= '0;
      row_cnt_reg   <= '0;
    end else begin
      vsync_d2_reg  <= vsync_d1_reg;
      href_d2_reg   <= href_d1_reg;
      clken_d2_reg  <= clken_d1_reg;
      win_valid_reg <= win_valid_next;
      armed_reg     <= armed_next;
      col_cnt_reg   <= col_cnt_next;
      row_cnt_reg   <= row_cnt_next;
    end
  end

  assign bus.post_frame_vsync = vsync_d2_reg;
  assign bus.post_frame_href  = href_d2_reg;
  assign bus.post_frame_clken = clken_d2_reg;
  assign bus.post_win_valid   = win_valid_reg;

  assign bus.m11 = g_row[0].px_reg[0];
  assign bus.m12 = g_row[0].px_reg[1];
  assign bus.m13 = g_row[0].px_reg[2];
  assign bus.m21 = g_row[1].px_reg[0];
  assign bus.m22 = g_row[1].px_reg[1];
  assign bus.m23 = g_row[1].px_reg[2];
  assign bus.m31 = g_row[2].px_reg[0];
  assign bus.m32 = g_row[2].px_reg[1];
  assign bus.m33 = g_row[2].px_reg[2];
endmodule

// File: tb/tb_matrix_3x3_gen_8bit.sv
// Scoreboard bench for matrix_3x3_gen_8bit: a line-buffer image model predicts
// every window; a negedge monitor checks windows and delayed syncs.
module tb_matrix_3x3_gen_8bit;
  localparam int IMG_VER = 8;
  localparam int CNT_W   = 10;

  typedef struct packed {
    logic        valid;
    logic [71:0] win;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_3x3_gen_8bit_if bus ();

  matrix_3x3_gen_8bit #(
    .IMG_HOR(640),
    .IMG_VER(IMG_VER),
    .CNT_W  (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;
  int n_win = 0;
  int valid_seen = 0;

  exp_t sb_q[$];
  exp_t mon_e;

  // Image model: previous two lines, current line, window and position.
  logic [7:0] cur [2048];
  logic [7:0] ln1 [2048];
  logic [7:0] ln2 [2048];
  logic [7:0] w [3][3];
  logic [7:0] pend1, pend2;
  int x = 0;
  int y = 0;
  bit armed_m = 1'b0;

  logic [2:0] h1, h2;

  function automatic logic [71:0] dut_win();
    return {bus.m11, bus.m12, bus.m13, bus.m21, bus.m22, bus.m23,
            bus.m31, bus.m32, bus.m33};
  endfunction

  function automatic logic [71:0] model_win();
    return {w[0][0], w[0][1], w[0][2], w[1][0], w[1][1], w[1][2],
            w[2][0], w[2][1], w[2][2]};
  endfunction

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("[TB] check %s ok value=%h", name, act);
    end
  endtask

  // One input cycle; taps for the previous cycle's pixel are presented now.
  task automatic drive_cycle(input logic vs, input logic hr, input logic ce, input logic [7:0] pix);
    exp_t e;
    @(posedge clk);
    #1;
    bus.row1_tap        = pend1;
    bus.row2_tap        = pend2;
    bus.pre_frame_vsync = vs;
    bus.pre_frame_href  = hr;
    bus.pre_frame_clken = ce;
    bus.pre_img_y       = pix;
    if (ce) begin
      pend1  = ln2[x];
      pend2  = ln1[x];
      cur[x] = pix;
      for (int r = 0; r < 3; r++) begin
        w[r][0] = w[r][1];
        w[r][1] = w[r][2];
      end
      w[0][2] = ln2[x];
      w[1][2] = ln1[x];
      w[2][2] = pix;
      e.valid = armed_m && (x >= 2) && (y >= 2);
      e.win   = model_win();
      sb_q.push_back(e);
      if (x < 2047) x++;
    end else begin
      pend1 = 8'($urandom);
      pend2 = 8'($urandom);
    end
  endtask

  task automatic line_end(input bit vs_rise);
    drive_cycle(vs_rise, 1'b0, 1'b0, 8'($urandom));
    for (int i = 0; i < 2048; i++) begin
      ln2[i] = ln1[i];
      ln1[i] = cur[i];
    end
    x = 0;
    if (vs_rise) begin
      y = 0;
      armed_m = 1'b1;
    end else begin
      y++;
    end
    drive_cycle(vs_rise, 1'b0, 1'b0, 8'($urandom));
    drive_cycle(1'b0, 1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic frame_start();
    drive_cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
    y = 0;
    armed_m = 1'b1;
    drive_cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
    drive_cycle(1'b0, 1'b0, 1'b0, 8'($urandom));
    drive_cycle(1'b0, 1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic run_line(input int len, input bit pattern_pix, input int gap_pct, input bit vs_at_end);
    int n;
    logic [7:0] pix;
    n = 0;
    while (n < len) begin
      if (int'($urandom_range(99)) < gap_pct) begin
        drive_cycle(1'b0, 1'b1, 1'b0, 8'($urandom));
      end else begin
        pix = pattern_pix ? 8'(16 * y + n) : 8'($urandom);
        drive_cycle(1'b0, 1'b1, 1'b1, pix);
        n++;
      end
    end
    line_end(vs_at_end);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h1 <= 3'b000;
      h2 <= 3'b000;
    end else begin
      h1 <= {bus.pre_frame_vsync, bus.pre_frame_href, bus.pre_frame_clken};
      h2 <= h1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      tests++;
      if ({bus.post_frame_vsync, bus.post_frame_href, bus.post_frame_clken} !== h2) begin
        fails++;
        $display("FAIL post_sync actual=%b required=%b",
                 {bus.post_frame_vsync, bus.post_frame_href, bus.post_frame_clken}, h2);
      end
      if (bus.post_frame_clken === 1'b1) begin
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL sb_underflow actual=window_out required=no_window");
        end else begin
          mon_e = sb_q.pop_front();
          n_win++;
          if ({bus.post_win_valid, dut_win()} !== {mon_e.valid, mon_e.win}) begin
            fails++;
            $display("FAIL window_%0d actual=%b/%h required=%b/%h", n_win,
                     bus.post_win_valid, dut_win(), mon_e.valid, mon_e.win);
          end else begin
            $display("[TB] win %0d valid=%0b m=%h", n_win, mon_e.valid, mon_e.win);
          end
          if (bus.post_win_valid === 1'b1) valid_seen++;
        end
      end
    end
  end

  initial begin
    int v0;
    logic [8:0] gpat;
    bus.pre_frame_vsync = 1'b0;
    bus.pre_frame_href  = 1'b0;
    bus.pre_frame_clken = 1'b0;
    bus.pre_img_y       = 8'd0;
    bus.row1_tap        = 8'd0;
    bus.row2_tap        = 8'd0;
    pend1 = 8'd0;
    pend2 = 8'd0;
    for (int i = 0; i < 2048; i++) begin
      cur[i] = 8'd0;
      ln1[i] = 8'd0;
      ln2[i] = 8'd0;
    end
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) w[r][c] = 8'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_win", {8'd0, dut_win()}, 80'd0);
    check("reset_flags", {76'd0, bus.post_frame_vsync, bus.post_frame_href,
                          bus.post_frame_clken, bus.post_win_valid}, 80'd0);
    rst_n = 1'b1;
    repeat (2) drive_cycle(1'b0, 1'b0, 1'b0, 8'd0);

    // Lines before any frame start never produce a valid window
    for (int l = 0; l < 4; l++) run_line(6, 1'b0, 20, 1'b0);

    // 4x4 frame with pixel = 16*y + x: exactly four valid windows
    frame_start();
    v0 = valid_seen;
    for (int l = 0; l < 4; l++) run_line(4, 1'b1, 0, 1'b0);
    check("valid_pulses_4x4", 80'(valid_seen - v0), 80'd4);

    // Latency: a single pixel reaches m33 two cycles later and holds through a gap
    frame_start();
    run_line(4, 1'b0, 0, 1'b0);
    run_line(4, 1'b0, 0, 1'b0);
    drive_cycle(1'b0, 1'b1, 1'b1, 8'hA5);
    drive_cycle(1'b0, 1'b1, 1'b0, 8'($urandom));
    drive_cycle(1'b0, 1'b1, 1'b0, 8'($urandom));
    check("latency_m33", {71'd0, bus.post_frame_clken, bus.m33}, {71'd0, 1'b1, 8'hA5});
    drive_cycle(1'b0, 1'b1, 1'b0, 8'($urandom));
    check("hold_window", {7'd0, bus.post_frame_clken, dut_win()}, {7'd0, 1'b0, model_win()});
    drive_cycle(1'b0, 1'b1, 1'b1, 8'($urandom));
    drive_cycle(1'b0, 1'b1, 1'b1, 8'($urandom));
    line_end(1'b0);

    // Clken gaps 1,0,1,1,0,0,1,1,1 inside one line
    gpat = 9'b111001101;
    for (int i = 0; i < 9; i++)
      drive_cycle(1'b0, 1'b1, gpat[i], 8'($urandom));
    line_end(1'b0);

    // Random back-to-back frames; frame 1 ends with vsync rising as href falls
    frame_start();
    for (int f = 0; f < 2; f++)
      for (int l = 0; l < 10; l++)
        run_line(int'($urandom_range(3, 12)), 1'b0, 30, (f == 0) && (l == 9));

    // Column counter saturation on a 1030-pixel line
    run_line(1030, 1'b0, 0, 1'b0);

    // Mid-stream reset
    for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b1, 1'b1, 8'($urandom));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset_win", {8'd0, dut_win()}, 80'd0);
    check("midreset_flags", {76'd0, bus.post_frame_vsync, bus.post_frame_href,
                             bus.post_frame_clken, bus.post_win_valid}, 80'd0);
    sb_q.delete();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) w[r][c] = 8'd0;
    x = 0;
    y = 0;
    armed_m = 1'b0;
    repeat (2) drive_cycle(1'b0, 1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;
    drive_cycle(1'b0, 1'b0, 1'b0, 8'd0);
    v0 = valid_seen;
    for (int l = 0; l < 4; l++) run_line(6, 1'b0, 10, 1'b0);
    check("no_valid_after_reset", 80'(valid_seen - v0), 80'd0);
    frame_start();
    for (int l = 0; l < 4; l++) run_line(6, 1'b0, 10, 1'b0);

    repeat (4) drive_cycle(1'b0, 1'b0, 1'b0, 8'd0);
    check("sb_drained", 80'(sb_q.size()), 80'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/matrix_3x3_gen_8bit.md
Name: matrix_3x3_gen_8bit

Overview:
- Consumes the two delayed-line taps of the 8-bit line-shift RAM stage, together with the current-line pixel and frame syncs.
- Produces a registered 3x3 pixel window (m11..m33), sync signals delayed to match, and a window-valid flag. The flag marks windows that lie fully inside the image.
- Feeds downstream 3x3 kernels (Sobel, median, Gaussian) in the image-processor pipeline.

Parameters:
- IMG_HOR, 640, active pixels per line. Must be ≤ 2^CNT_W.
- IMG_VER, 480, active lines per frame. Row counter saturates at IMG_VER-1.
- CNT_W, 10, width of the column and row counters. Matches the 1024-deep line RAM.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- pre_frame_vsync  in  1  active-high frame sync; rising edge = frame start
- pre_frame_href  in  1  active-high line valid
- pre_frame_clken  in  1  pixel strobe, valid only while href=1
- pre_img_y  in  8  current-line pixel, valid with clken
- row1_tap  in  8  pixel two lines above (line RAM taps1x); valid the cycle after clken
- row2_tap  in  8  pixel one line above (line RAM taps0x); valid the cycle after clken
- post_frame_vsync  out  1  vsync delayed 2 cycles
- post_frame_href  out  1  href delayed 2 cycles
- post_frame_clken  out  1  clken delayed 2 cycles
- post_win_valid  out  1  window fully inside image; qualified by post_frame_clken
- m11,m12,m13  out  8 each  top row (oldest line), left→right; m13 newest column
- m21,m22,m23  out  8 each  middle row
- m31,m32,m33  out  8 each  bottom row (current line)

Behaviour:
- Reset (rst_n=0, async): all m** = 0. post_* syncs = 0. post_win_valid = 0. Counters = 0. armed = 0.
- Stage 1 (cycle t+1 after input at t):
  - register pre_img_y into row3_d, plus vsync/href/clken into *_d1.
  - The line RAM taps are valid this cycle. Sample row1_tap and row2_tap as the column aligned with row3_d.
- Stage 2 (cycle t+2): if clken_d1=1, shift each window row left (mX1<=mX2, mX2<=mX3). Load new column: m13<=row1_tap, m23<=row2_tap, m33<=row3_d.
- If clken_d1=0, the window holds. Gaps in clken inside a line are legal and never corrupt the window.
- Total latency: pixel at input clken cycle t appears in m33 at t+2. post_frame_* = pre_frame_* delayed exactly 2 cycles.
- Column counter col_cnt (aligned to stage 2):
  - cleared while href_d1=0.
  - increments by 1 on each clken_d1.
  - saturates at 2^CNT_W-1, no wrap.
  - the value used for a window is the x index of its newest column m*3 (0-based).
- Row counter row_cnt:
  - cleared on the vsync_d1 rising edge.
  - increments on each href_d1 falling edge.
  - saturates at IMG_VER-1.
  - gives the y index of row 3.
- armed flag: set on the first vsync_d1 rising edge after reset; never cleared except by reset.
  - Windows after a mid-frame reset are suppressed until the next frame start.
- post_win_valid (registered, stage 2) = armed & clken_d1 & (col_cnt ≥ 2) & (row_cnt ≥ 2), evaluated with col_cnt before its increment.
  - The center pixel m22 is then image pixel (x-1, y-1).
- Edge windows: contents are stale data from the previous line or frame. The block does no padding or replication.
- Simultaneous vsync rise and href fall in one cycle: clear takes priority; row_cnt = 0.
- All outputs are registered; no combinational input-to-output path.

Test Plan:
- Reset: assert rst_n=0 mid-stream → all m**=0, post_*=0, post_win_valid=0 immediately; after release, no valid until the next vsync rising edge.
- 4x4 frame, pixel value = 16·y+x, taps driven as a model of the line RAM:
  - → post_win_valid pulses exactly 4 times, at (x,y) = (2,2),(3,2),(2,3),(3,3).
  - for the first valid window, m11..m33 = 00,01,02,10,11,12,20,21,22 (hex).
- Latency: single clken at cycle t with pre_img_y=8'hA5 → m33=A5 and post_frame_clken=1 at t+2; window unchanged at t+3 with clken low.
- Clken gaps: line of 6 pixels with clken 1,0,1,1,0,0,1,1,1 → window shifts only on delayed clken; the m31..m33 sequence matches a gapless reference; col_cnt ends at 6.
- Frame restart: two back-to-back frames → row_cnt clears on the second vsync rise; the first two lines of frame 2 produce no valid, even though taps carry frame-1 data.
- Saturation: 1030-pixel line with CNT_W=10 → col_cnt holds 1023, no wrap; valid stays high, no glitch.
